// File: rtl/three_eight_pkg.sv
// Shared types and widths for the 3:8 pulse decoder and its phase timer.
package three_eight_pkg;

  localparam int DEC_CODE_W = 3;
  localparam int DEC_OUT_W  = 8;
  localparam int TIMER_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    GAP   = 2'b10
  } dec_state_e;

  // An X/Z code yields an X select bus; there is deliberately no recovery.
  function automatic logic [DEC_OUT_W-1:0] onehot(input logic [DEC_CODE_W-1:0] code);
    return DEC_OUT_W'(1) << code;
  endfunction

endpackage

// File: rtl/dec_len_timer.sv
// Loadable down-counter shared by the DRIVE and GAP phases; clr beats load beats dec.
module dec_len_timer
  import three_eight_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  input  logic               clr,
  output logic               zero
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/three_eight_pulse_decoder.sv
// 3-bit code in over valid/ready, registered one-hot pulse out for PULSE_LEN cycles, then a GAP_LEN quiet gap.
// Optional completion counter port done_cnt is built when THREE_EIGHT_DONE_CNT_EN is defined.
module three_eight_pulse_decoder
  import three_eight_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DEC_CODE_W-1:0] in_code,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DEC_OUT_W-1:0]  out,
  output logic                  out_active,
  output logic                  done
`ifdef THREE_EIGHT_DONE_CNT_EN
  ,
  output logic [7:0]            done_cnt
`endif
);

  if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_pulse_len
    $error("three_eight_pulse_decoder: PULSE_LEN must be in 1..255");
  end
  if (GAP_LEN < 0 || GAP_LEN > 255) begin : g_bad_gap_len
    $error("three_eight_pulse_decoder: GAP_LEN must be in 0..255");
  end

  localparam bit                 HAS_GAP    = (GAP_LEN > 0);
  localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_LEN - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(HAS_GAP ? GAP_LEN - 1 : 0);

  dec_state_e            state_q, state_d;
  logic [DEC_OUT_W-1:0]  out_q, out_d;
  logic                  out_active_q, out_active_d;
  logic                  done_q, done_d;
  logic [DEC_CODE_W-1:0] code_q, code_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_load_val;
  logic               tmr_dec;
  logic               tmr_clr;
  logic               tmr_zero;
  logic               accept;

  assign in_ready = en && (state_q == IDLE);
  assign accept   = in_valid && in_ready;

  dec_len_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .clr      (tmr_clr),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    out_active_d = out_active_q;
    done_d       = 1'b0;
    code_d       = code_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    tmr_clr      = 1'b0;

    // Dropping en anywhere outside IDLE abandons the pulse without a done.
    if (!en && (state_q != IDLE)) begin
      state_d      = IDLE;
      out_d        = '0;
      out_active_d = 1'b0;
      tmr_clr      = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            code_d       = in_code;
            out_d        = onehot(in_code);
            out_active_d = 1'b1;
            tmr_load     = 1'b1;
            tmr_load_val = PULSE_LOAD;
            state_d      = DRIVE;
          end
        end
        DRIVE: begin
          if (tmr_zero) begin
            out_d        = '0;
            out_active_d = 1'b0;
            done_d       = 1'b1;
            if (HAS_GAP) begin
              tmr_load     = 1'b1;
              tmr_load_val = GAP_LOAD;
              state_d      = GAP;
            end else begin
              state_d = IDLE;
            end
          end else begin
            out_d   = onehot(code_q);
            tmr_dec = 1'b1;
          end
        end
        GAP: begin
          if (tmr_zero) begin
            state_d = IDLE;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: begin
          state_d      = IDLE;
          out_d        = '0;
          out_active_d = 1'b0;
          tmr_clr      = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      out_q        <= '0;
      out_active_q <= 1'b0;
      done_q       <= 1'b0;
      code_q       <= '0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      out_active_q <= out_active_d;
      done_q       <= done_d;
      code_q       <= code_d;
    end
  end

  assign out        = out_q;
  assign out_active = out_active_q;
  assign done       = done_q;

`ifdef THREE_EIGHT_DONE_CNT_EN
  logic [7:0] done_cnt_q, done_cnt_d;

  // Counts edges that see done high; saturates instead of wrapping.
  always_comb begin
    done_cnt_d = done_cnt_q;
    if (done_q && (done_cnt_q != 8'hFF)) begin
      done_cnt_d = done_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_q <= 8'h00;
    end else begin
      done_cnt_q <= done_cnt_d;
    end
  end

  assign done_cnt = done_cnt_q;
`endif

endmodule

// File: tb/tb_three_eight_pulse_decoder.sv
// Scoreboard bench: three decoder instances (4/1, 2/0, 1/0) checked against expected pulses queued at stimulus time.
module tb_three_eight_pulse_decoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] out;
    int         len;
    bit         done;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  logic       en_a = 1'b1, valid_a = 1'b0, ready_a, act_a, done_a;
  logic [2:0] code_a = 3'd0;
  logic [7:0] out_a;
  logic       en_b = 1'b1, valid_b = 1'b0, ready_b, act_b, done_b;
  logic [2:0] code_b = 3'd0;
  logic [7:0] out_b;
  logic       en_c = 1'b1, valid_c = 1'b0, ready_c, act_c, done_c;
  logic [2:0] code_c = 3'd0;
  logic [7:0] out_c;
`ifdef THREE_EIGHT_DONE_CNT_EN
  logic [7:0] done_cnt_a, done_cnt_b, done_cnt_c;
`endif

  three_eight_pulse_decoder #(.PULSE_LEN(4), .GAP_LEN(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .in_code(code_a), .in_valid(valid_a),
    .in_ready(ready_a), .out(out_a), .out_active(act_a), .done(done_a)
`ifdef THREE_EIGHT_DONE_CNT_EN
    , .done_cnt(done_cnt_a)
`endif
  );

  three_eight_pulse_decoder #(.PULSE_LEN(2), .GAP_LEN(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .in_code(code_b), .in_valid(valid_b),
    .in_ready(ready_b), .out(out_b), .out_active(act_b), .done(done_b)
`ifdef THREE_EIGHT_DONE_CNT_EN
    , .done_cnt(done_cnt_b)
`endif
  );

  three_eight_pulse_decoder #(.PULSE_LEN(1), .GAP_LEN(0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .in_code(code_c), .in_valid(valid_c),
    .in_ready(ready_c), .out(out_c), .out_active(act_c), .done(done_c)
`ifdef THREE_EIGHT_DONE_CNT_EN
    , .done_cnt(done_cnt_c)
`endif
  );

  // Pulse monitor for instances A (index 0) and B (index 1), sampling on the falling edge.
  bit   mon_en = 1'b1;
  bit   m_prev [2] = '{1'b0, 1'b0};
  int   m_len  [2] = '{0, 0};
  exp_t m_cur  [2];

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      for (int i = 0; i < 2; i++) begin
        logic [7:0] o;
        logic       a;
        logic       d;
        o = (i == 0) ? out_a  : out_b;
        a = (i == 0) ? act_a  : act_b;
        d = (i == 0) ? done_a : done_b;
        if (a === 1'b1) begin
          if (!m_prev[i]) begin
            m_len[i] = 0;
            checks++;
            if (i == 0 && q_a.size() > 0) m_cur[i] = q_a.pop_front();
            else if (i == 1 && q_b.size() > 0) m_cur[i] = q_b.pop_front();
            else begin
              errors++;
              $display("FAIL sb_unexpected_pulse inst=%0d got out=%h exp no pulse", i, o);
              m_cur[i] = '{out: o, len: 0, done: 1'b0};
            end
          end
          m_len[i]++;
          checks++;
          if (o !== m_cur[i].out) begin
            errors++;
            $display("FAIL sb_out inst=%0d got=%h exp=%h", i, o, m_cur[i].out);
          end
        end else if (m_prev[i]) begin
          checks++;
          if (m_len[i] != m_cur[i].len) begin
            errors++;
            $display("FAIL sb_len inst=%0d got=%0d exp=%0d", i, m_len[i], m_cur[i].len);
          end
          checks++;
          if (d !== m_cur[i].done) begin
            errors++;
            $display("FAIL sb_done_at_end inst=%0d got=%b exp=%b", i, d, m_cur[i].done);
          end
        end else begin
          checks++;
          if (d !== 1'b0) begin
            errors++;
            $display("FAIL sb_stray_done inst=%0d got=%b exp=0", i, d);
          end
        end
        checks++;
        if (a !== (o != 8'h00)) begin
          errors++;
          $display("FAIL sb_active_match inst=%0d got act=%b out=%h", i, a, o);
        end
        checks++;
        if ($countones(o) > 1) begin
          errors++;
          $display("FAIL sb_onehot inst=%0d got=%h exp at most one bit", i, o);
        end
        m_prev[i] = (a === 1'b1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready_a();
    int n = 0;
    while (ready_a !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (ready_a !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready_a_timeout got=%b exp=1", ready_a);
    end
  endtask

  task automatic test_reset();
    en_a = 1'b1; valid_a = 1'b1; code_a = 3'd3;
    repeat (2) step();
    checks++; if (out_a !== 8'h00)  begin errors++; $display("FAIL reset_out got=%h exp=00", out_a); end
    checks++; if (act_a !== 1'b0)   begin errors++; $display("FAIL reset_active got=%b exp=0", act_a); end
    checks++; if (done_a !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b exp=0", done_a); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_a); end
    checks++; if (out_b !== 8'h00)  begin errors++; $display("FAIL reset_out_b got=%h exp=00", out_b); end
`ifdef THREE_EIGHT_DONE_CNT_EN
    checks++; if (done_cnt_c !== 8'h00) begin errors++; $display("FAIL reset_done_cnt got=%h exp=00", done_cnt_c); end
`endif
    rst_n = 1'b1;
  endtask

  // Accept of code 3 happens at the first edge after reset release.
  task automatic test_single_pulse();
    logic [7:0] eo [6];
    logic       ed [6];
    logic       er [6];
    eo = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00};
    ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    q_a.push_back('{out: 8'h08, len: 4, done: 1'b1});
    step();
    valid_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      checks++; if (out_a !== eo[i])   begin errors++; $display("FAIL single_out[%0d] got=%h exp=%h", i, out_a, eo[i]); end
      checks++; if (done_a !== ed[i])  begin errors++; $display("FAIL single_done[%0d] got=%b exp=%b", i, done_a, ed[i]); end
      checks++; if (ready_a !== er[i]) begin errors++; $display("FAIL single_ready[%0d] got=%b exp=%b", i, ready_a, er[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] eo [6];
    logic       ed [6];
    logic       er [6];
    eo = '{8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h00};
    ed = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    er = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    q_b.push_back('{out: 8'h01, len: 2, done: 1'b1});
    q_b.push_back('{out: 8'h80, len: 2, done: 1'b1});
    valid_b = 1'b1; code_b = 3'd0;
    step();
    code_b = 3'd7;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      checks++; if (out_b !== eo[i])   begin errors++; $display("FAIL b2b_out[%0d] got=%h exp=%h", i, out_b, eo[i]); end
      checks++; if (done_b !== ed[i])  begin errors++; $display("FAIL b2b_done[%0d] got=%b exp=%b", i, done_b, ed[i]); end
      checks++; if (ready_b !== er[i]) begin errors++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, ready_b, er[i]); end
      if (i == 3) valid_b = 1'b0;
    end
  endtask

  task automatic test_abort();
    wait_ready_a();
    q_a.push_back('{out: 8'h20, len: 2, done: 1'b0});
    code_a = 3'd5; valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    checks++; if (out_a !== 8'h20) begin errors++; $display("FAIL abort_first got=%h exp=20", out_a); end
    step();
    checks++; if (out_a !== 8'h20) begin errors++; $display("FAIL abort_second got=%h exp=20", out_a); end
    en_a = 1'b0;
    #1;
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL abort_ready_en_low got=%b exp=0", ready_a); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (out_a !== 8'h00)  begin errors++; $display("FAIL abort_out[%0d] got=%h exp=00", i, out_a); end
      checks++; if (act_a !== 1'b0)   begin errors++; $display("FAIL abort_active[%0d] got=%b exp=0", i, act_a); end
      checks++; if (done_a !== 1'b0)  begin errors++; $display("FAIL abort_done[%0d] got=%b exp=0", i, done_a); end
      checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL abort_ready[%0d] got=%b exp=0", i, ready_a); end
    end
    en_a = 1'b1;
    #1;
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL abort_ready_restored got=%b exp=1", ready_a); end
  endtask

  task automatic test_en_low_idle();
    en_a = 1'b0; valid_a = 1'b1; code_a = 3'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_a !== 8'h00)  begin errors++; $display("FAIL idle_en_low_out[%0d] got=%h exp=00", i, out_a); end
      checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL idle_en_low_ready[%0d] got=%b exp=0", i, ready_a); end
    end
    valid_a = 1'b0; en_a = 1'b1;
    step();
  endtask

  task automatic test_ignored_input();
    wait_ready_a();
    q_a.push_back('{out: 8'h02, len: 4, done: 1'b1});
    code_a = 3'd1; valid_a = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_a !== 8'h02) begin errors++; $display("FAIL ignore_drive_out[%0d] got=%h exp=02", i, out_a); end
      code_a  = 3'($urandom_range(0, 7));
      valid_a = 1'($urandom_range(0, 1));
      step();
    end
    checks++; if (done_a !== 1'b1)  begin errors++; $display("FAIL ignore_done got=%b exp=1", done_a); end
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL ignore_gap_ready got=%b exp=0", ready_a); end
    code_a = 3'd4; valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL ignore_ready_back got=%b exp=1", ready_a); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_a !== 8'h00) begin errors++; $display("FAIL ignore_no_accept[%0d] got=%h exp=00", i, out_a); end
      step();
    end
  endtask

  task automatic test_pulse_len_one();
    code_c = 3'd6; valid_c = 1'b1;
    step();
    valid_c = 1'b0;
    checks++; if (out_c !== 8'h40)   begin errors++; $display("FAIL p1_out got=%h exp=40", out_c); end
    step();
    checks++; if (out_c !== 8'h00)   begin errors++; $display("FAIL p1_out_end got=%h exp=00", out_c); end
    checks++; if (done_c !== 1'b1)   begin errors++; $display("FAIL p1_done got=%b exp=1", done_c); end
    checks++; if (ready_c !== 1'b1)  begin errors++; $display("FAIL p1_ready_with_done got=%b exp=1", ready_c); end
    step();
    checks++; if (done_c !== 1'b0)   begin errors++; $display("FAIL p1_done_once got=%b exp=0", done_c); end
  endtask

  // Streams n accepts into instance C; each queued one-hot is checked the cycle it appears.
  task automatic run_c(input int n);
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int acc  = 0;
    int seen = 0;
    valid_c = 1'b1;
    for (int cyc = 0; cyc < 4 * n + 8; cyc++) begin
      if (acc < n) code_c = 3'($urandom_range(0, 7));
      else valid_c = 1'b0;
      if (valid_c && ready_c) begin
        exp_q.push_back(8'h01 << code_c);
        acc++;
      end
      step();
      if (done_c === 1'b1) seen++;
      if (act_c === 1'b1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        checks++;
        if (out_c !== e) begin errors++; $display("FAIL c_out got=%h exp=%h", out_c, e); end
      end
      if (acc >= n && seen >= n) break;
    end
    valid_c = 1'b0;
    checks++;
    if (seen != n) begin errors++; $display("FAIL c_done_pulses got=%0d exp=%0d", seen, n); end
  endtask

`ifdef THREE_EIGHT_DONE_CNT_EN
  task automatic test_done_cnt();
    run_c(10);
    repeat (2) step();
    checks++; if (done_cnt_c !== 8'd10) begin errors++; $display("FAIL cnt_10 got=%0d exp=10", done_cnt_c); end
    for (int k = 0; k < 3; k++) begin
      code_c = 3'(k); valid_c = 1'b1;
      step();
      valid_c = 1'b0; en_c = 1'b0;
      step();
      checks++; if (done_c !== 1'b0) begin errors++; $display("FAIL cnt_abort_done[%0d] got=%b exp=0", k, done_c); end
      en_c = 1'b1;
      step();
    end
    repeat (2) step();
    checks++; if (done_cnt_c !== 8'd10) begin errors++; $display("FAIL cnt_after_abort got=%0d exp=10", done_cnt_c); end
    run_c(290);
    repeat (2) step();
    checks++; if (done_cnt_c !== 8'hFF) begin errors++; $display("FAIL cnt_saturate got=%h exp=ff", done_cnt_c); end
    run_c(5);
    repeat (2) step();
    checks++; if (done_cnt_c !== 8'hFF) begin errors++; $display("FAIL cnt_hold got=%h exp=ff", done_cnt_c); end
  endtask
`endif

  task automatic test_async_reset();
    wait_ready_a();
    mon_en = 1'b0;
    code_a = 3'd0; valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_a !== 8'h00) begin errors++; $display("FAIL async_rst_out got=%h exp=00", out_a); end
    checks++; if (act_a !== 1'b0)  begin errors++; $display("FAIL async_rst_active got=%b exp=0", act_a); end
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL async_rst_ready got=%b exp=1", ready_a); end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_back_to_back();
    test_abort();
    test_en_low_idle();
    test_ignored_input();
    test_pulse_len_one();
`ifdef THREE_EIGHT_DONE_CNT_EN
    test_done_cnt();
`endif
    repeat (6) step();
    checks++; if (q_a.size() != 0) begin errors++; $display("FAIL sb_drain_a got=%0d exp=0", q_a.size()); end
    checks++; if (q_b.size() != 0) begin errors++; $display("FAIL sb_drain_b got=%0d exp=0", q_b.size()); end
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
